// File: rtl/pch_update_unit_pkg.sv
// Shared definitions for the PC high-byte update unit: fixup state encoding and PCH width.
package pch_update_unit_pkg;
  localparam int PCH_WIDTH = 8;

  typedef enum logic {
    PCH_IDLE  = 1'b0,
    PCH_FIXUP = 1'b1
  } pch_state_t;
endpackage

// File: rtl/pch_update_unit_fixup_fsm.sv
// Branch page-cross fixup sequencer: captures the correction direction and
// holds a registered stall for the single FIXUP cycle.
module pch_fixup_fsm
  import pch_update_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic branch_fix,
  input  logic branch_carry,
  input  logic branch_sign,
  output logic up,
  output logic stall
);
  pch_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PCH_IDLE;
      up    <= 1'b0;
      stall <= 1'b0;
    end else begin
      case (state)
        PCH_IDLE: begin
          // Carry and offset sign disagreeing means PCL left its page.
          if (branch_fix && (branch_carry ^ branch_sign)) begin
            state <= PCH_FIXUP;
            up    <= ~branch_sign;
            stall <= 1'b1;
          end
        end
        PCH_FIXUP: begin
          state <= PCH_IDLE;
          stall <= 1'b0;
        end
        default: begin
          state <= PCH_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/pch_update_unit.sv
// PCH register, incrementer, bus drivers and branch page-cross fixup.
// Optional PCH_FIXUP_COUNTER_EN adds a saturating count of completed fixups.
module pch_update_unit
  import pch_update_unit_pkg::*;
#(
  parameter logic [PCH_WIDTH-1:0] RESET_VALUE = 8'h00
) (
  input  logic                 clk_IN,
  input  logic                 reset_IN,
  input  logic [PCH_WIDTH-1:0] pcHighSel_IN,
  input  logic                 load_EN,
  input  logic                 pclCarry_IN,
  input  logic                 branchFix_EN,
  input  logic                 branchCarry_IN,
  input  logic                 branchSign_IN,
  input  logic                 pchToAddr_EN,
  input  logic                 pchToData_EN,
  output logic [PCH_WIDTH-1:0] pcHigh_OUT,
  output logic [PCH_WIDTH-1:0] addressHigh_OUT,
  output logic [PCH_WIDTH-1:0] dataBus_OUT,
`ifdef PCH_FIXUP_COUNTER_EN
  output logic [15:0]          fixupCount_OUT,
`endif
  output logic                 stall_OUT
);
  logic                 fix_up;
  logic                 in_fixup;
  logic [PCH_WIDTH-1:0] pch;

  pch_fixup_fsm u_fsm (
    .clk          (clk_IN),
    .rst          (reset_IN),
    .branch_fix   (branchFix_EN),
    .branch_carry (branchCarry_IN),
    .branch_sign  (branchSign_IN),
    .up           (fix_up),
    .stall        (in_fixup)
  );

  // FIXUP takes priority: the sequencer is stalled, so load requests are dropped.
  always_ff @(posedge clk_IN or posedge reset_IN) begin
    if (reset_IN)
      pch <= RESET_VALUE;
    else if (in_fixup)
      pch <= fix_up ? pch + 8'd1 : pch - 8'd1;
    else if (load_EN)
      pch <= pcHighSel_IN + {{(PCH_WIDTH-1){1'b0}}, pclCarry_IN};
  end

`ifdef PCH_FIXUP_COUNTER_EN
  always_ff @(posedge clk_IN or posedge reset_IN) begin
    if (reset_IN)
      fixupCount_OUT <= 16'h0000;
    else if (in_fixup && fixupCount_OUT != 16'hFFFF)
      fixupCount_OUT <= fixupCount_OUT + 16'd1;
  end
`endif

  assign pcHigh_OUT      = pch;
  assign stall_OUT       = in_fixup;
  assign addressHigh_OUT = pchToAddr_EN ? pch : '0;
  assign dataBus_OUT     = pchToData_EN ? pch : '0;
endmodule

// File: tb/tb_pch_update_unit.sv
// Bench for pch_update_unit: directed vector table, reset corner cases, and
// random traffic against a cycle-level reference model.
module tb_pch_update_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sel;
  logic       load, pcarry, bfix, bcarry, bsign, to_addr, to_data;
  logic [7:0] pch_o, addr_o, data_o;
  logic       stall_o;
`ifdef PCH_FIXUP_COUNTER_EN
  logic [15:0] cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_pch;
  bit m_pending;
  bit m_up;
  int m_cnt;

  always #5 clk = ~clk;

  pch_update_unit #(.RESET_VALUE(8'h00)) dut (
    .clk_IN          (clk),
    .reset_IN        (rst),
    .pcHighSel_IN    (sel),
    .load_EN         (load),
    .pclCarry_IN     (pcarry),
    .branchFix_EN    (bfix),
    .branchCarry_IN  (bcarry),
    .branchSign_IN   (bsign),
    .pchToAddr_EN    (to_addr),
    .pchToData_EN    (to_data),
    .pcHigh_OUT      (pch_o),
    .addressHigh_OUT (addr_o),
    .dataBus_OUT     (data_o),
`ifdef PCH_FIXUP_COUNTER_EN
    .fixupCount_OUT  (cnt_o),
`endif
    .stall_OUT       (stall_o)
  );

  typedef struct {
    bit       load;
    bit [7:0] sel;
    bit       pcarry;
    bit       bfix;
    bit       bcarry;
    bit       bsign;
    bit       to_addr;
    bit       to_data;
    bit [7:0] exp_pch;
    bit       exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pch = 0; m_pending = 0; m_up = 0; m_cnt = 0;
  endfunction

  // One rising edge of the abstract machine: a pending correction consumes the
  // cycle; otherwise a load and/or a new page-cross decision are taken.
  function automatic void model_edge();
    if (m_pending) begin
      m_pch = m_up ? (m_pch + 1) % 256 : (m_pch + 255) % 256;
      m_pending = 0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      if (load) m_pch = (int'(sel) + int'(pcarry)) % 256;
      if (bfix && (bcarry != bsign)) begin
        m_pending = 1;
        m_up = !bsign;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".pch"},   pch_o,   m_pch);
    check({tag, ".stall"}, stall_o, int'(m_pending));
    check({tag, ".addr"},  addr_o,  to_addr ? m_pch : 0);
    check({tag, ".data"},  data_o,  to_data ? m_pch : 0);
`ifdef PCH_FIXUP_COUNTER_EN
    check({tag, ".cnt"},   cnt_o,   m_cnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; sel = 0; pcarry = 0; bfix = 0; bcarry = 0; bsign = 0;
  endtask

  task automatic add(input bit l, input bit [7:0] s, input bit pc, input bit bf,
                     input bit bc, input bit bs, input bit ta, input bit td,
                     input bit [7:0] ep, input bit es);
    vec_t v;
    v.load = l; v.sel = s; v.pcarry = pc; v.bfix = bf; v.bcarry = bc; v.bsign = bs;
    v.to_addr = ta; v.to_data = td; v.exp_pch = ep; v.exp_stall = es;
    vecs.push_back(v);
  endtask

  initial begin
    //  load sel    pc bf bc bs ta td  pch    stall
    add(1, 8'h12, 1, 0, 0, 0, 1, 0, 8'h13, 0);
    add(1, 8'hFF, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    add(1, 8'h20, 0, 0, 0, 0, 1, 1, 8'h20, 0);
    add(0, 8'h00, 0, 1, 1, 0, 1, 0, 8'h20, 1); // forward cross
    add(1, 8'hAA, 0, 1, 0, 1, 0, 1, 8'h21, 0); // load/branch ignored in FIXUP
    add(0, 8'h00, 0, 1, 0, 1, 1, 1, 8'h21, 1); // backward cross
    add(0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h20, 0);
    add(0, 8'h00, 0, 1, 1, 1, 1, 0, 8'h20, 0); // no cross
    add(0, 8'h00, 0, 1, 0, 0, 0, 1, 8'h20, 0); // no cross
    add(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00, 1);
    add(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'hFF, 0); // 00 - 1 wraps
    add(1, 8'h30, 0, 1, 1, 0, 0, 0, 8'h30, 1); // load + cross together
    add(0, 8'h00, 0, 0, 0, 0, 1, 0, 8'h31, 0);

    idle_inputs(); to_addr = 1; to_data = 0;
    rst = 1;
    model_reset();
    #12;
    check("reset.pch",   pch_o,   8'h00);
    check("reset.stall", stall_o, 0);
    check("reset.addr",  addr_o,  8'h00);
    check("reset.data",  data_o,  8'h00);
    @(negedge clk); rst = 0;

    foreach (vecs[i]) begin
      load = vecs[i].load; sel = vecs[i].sel; pcarry = vecs[i].pcarry;
      bfix = vecs[i].bfix; bcarry = vecs[i].bcarry; bsign = vecs[i].bsign;
      to_addr = vecs[i].to_addr; to_data = vecs[i].to_data;
      step();
      check($sformatf("vec%0d.pch", i),   pch_o,   vecs[i].exp_pch);
      check($sformatf("vec%0d.stall", i), stall_o, vecs[i].exp_stall);
      check($sformatf("vec%0d.addr", i),  addr_o,  vecs[i].to_addr ? vecs[i].exp_pch : 8'h00);
      check($sformatf("vec%0d.data", i),  data_o,  vecs[i].to_data ? vecs[i].exp_pch : 8'h00);
    end
`ifdef PCH_FIXUP_COUNTER_EN
    check("vec.fixup_count", cnt_o, 4);
`endif

    // reset landing in the middle of FIXUP
    idle_inputs(); load = 1; sel = 8'h55;
    step();
    check("midfix.pre_pch", pch_o, 8'h55);
    idle_inputs(); bfix = 1; bcarry = 1;
    step();
    check("midfix.stall_hi", stall_o, 1);
    idle_inputs();
    #2 rst = 1;
    #1;
    model_reset();
    check("midfix.stall_async", stall_o, 0);
    check("midfix.pch_async",   pch_o,   8'h00);
`ifdef PCH_FIXUP_COUNTER_EN
    check("midfix.cnt", cnt_o, 0);
`endif
    @(posedge clk); #1;
    check("midfix.pch_held", pch_o, 8'h00);
    @(negedge clk); rst = 0;

    // random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      load    = ($urandom_range(0, 2) == 0);
      sel     = 8'($urandom_range(0, 255));
      pcarry  = 1'($urandom_range(0, 1));
      bfix    = ($urandom_range(0, 2) == 0);
      bcarry  = 1'($urandom_range(0, 1));
      bsign   = 1'($urandom_range(0, 1));
      to_addr = 1'($urandom_range(0, 1));
      to_data = 1'($urandom_range(0, 1));
      step();
      compare_all($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pch_update_unit.md
# pch_update_unit

Program-counter high-byte register and incrementer for the MOS 6502 core, sitting directly downstream of the PC high select stage. Each load cycle it takes the selected high byte, adds the carry from the PC low incrementer, and latches the PCH register. That register value feeds back into the select stage and drives the address-high and data buses. It also owns the one-cycle branch page-cross fixup: it corrects PCH and stalls the sequencer while doing so.

## Interface
- RESET_VALUE, 8'h00, PCH value after reset; the vector fetch overwrites it.
- clk_IN  input  1  core clock; all state updates on the rising edge.
- reset_IN  input  1  asynchronous, active-high reset.
- pcHighSel_IN  input  8  selected high byte from the PC high select stage.
- load_EN  input  1  latch the next PCH this cycle.
- pclCarry_IN  input  1  carry out of the PCL increment; only used when load_EN=1.
- branchFix_EN  input  1  a branch offset was added to PCL this cycle.
- branchCarry_IN  input  1  carry out of the PCL + offset add.
- branchSign_IN  input  1  bit 7 of the branch offset.
- pchToAddr_EN  input  1  drive PCH onto the address-high bus.
- pchToData_EN  input  1  drive PCH onto the data bus.
- pcHigh_OUT  output  8  PCH register; feeds back to the select stage.
- addressHigh_OUT  output  8  PCH when pchToAddr_EN=1, else 8'h00.
- dataBus_OUT  output  8  PCH when pchToData_EN=1, else 8'h00.
- stall_OUT  output  1  high for the whole fixup cycle.

## Operation
- Two states: IDLE and FIXUP. Reset state is IDLE.
- IDLE, load_EN=1: PCH <= pcHighSel_IN + pclCarry_IN, modulo 256. 8'hFF + 1 wraps to 8'h00; no carry-out is reported.
- IDLE, branchFix_EN=1: a page cross occurs iff branchCarry_IN XOR branchSign_IN.
  - Page cross: store the direction (up = !branchSign_IN) and go to FIXUP.
  - No page cross: stay in IDLE; PCH is unchanged unless load_EN is also high.
- IDLE, load_EN=1 and branchFix_EN=1 in the same cycle: the load is performed. The fixup decision is still captured, so FIXUP adjusts the newly loaded value.
- FIXUP:
  - PCH <= PCH + 1 if up, PCH - 1 if down, modulo 256. 8'h00 - 1 gives 8'hFF.
  - Always returns to IDLE after one cycle.
  - load_EN and branchFix_EN are ignored; the sequencer must hold off, and stall_OUT tells it to.
- Bus outputs are combinational from the PCH register. Both bus enables may be high at once.

## Timing
- Reset values: pcHigh_OUT = RESET_VALUE, stall_OUT = 0, state = IDLE. Bus outputs follow their enables (8'h00 when disabled).
- Load latency: 1 cycle. pcHigh_OUT shows the new value after the edge on which load_EN is sampled high.
- stall_OUT is registered. It is high for exactly the one cycle spent in FIXUP, starting the cycle after branchFix_EN is sampled with a page cross.
- Corrected PCH appears on the edge that ends FIXUP. This makes a page-crossing taken branch cost exactly one extra cycle.
- Reset asserted mid-FIXUP: immediate return to IDLE; stall_OUT drops asynchronously; PCH = RESET_VALUE.

## Configuration
- PCH_FIXUP_COUNTER_EN defined:
  - Adds the output fixupCount_OUT [15:0], which counts completed FIXUP cycles.
  - The counter saturates at 16'hFFFF and resets to 0.
- PCH_FIXUP_COUNTER_EN undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- Shared CPU package holds:
  - the typedef enum for the fixup state {PCH_IDLE, PCH_FIXUP};
  - the localparam PCH_WIDTH = 8.
- One sub-module is natural: pch_fixup_fsm (state, direction flag, stall_OUT). The register, adder and bus drivers stay in the top module.

## Test plan
- Reset with RESET_VALUE=8'h00 -> pcHigh_OUT=8'h00, stall_OUT=0; with pchToAddr_EN=1, addressHigh_OUT=8'h00.
- load_EN=1, pcHighSel_IN=8'h12, pclCarry_IN=1 -> pcHigh_OUT=8'h13 next cycle; with pcHighSel_IN=8'hFF, pclCarry_IN=1 -> 8'h00.
- PCH=8'h20, branchFix_EN=1, branchCarry_IN=1, branchSign_IN=0 -> stall_OUT=1 for one cycle, then PCH=8'h21; with branchCarry_IN=0, branchSign_IN=1 -> PCH=8'h1F.
- branchFix_EN=1, branchCarry_IN=1, branchSign_IN=1 -> no stall, PCH unchanged; PCH=8'h00 with a backward cross -> 8'hFF.
- During FIXUP, load_EN=1 with pcHighSel_IN=8'hAA -> ignored, PCH holds the fixup result; reset_IN pulsed mid-FIXUP -> stall_OUT=0 immediately, PCH=RESET_VALUE.
- With PCH_FIXUP_COUNTER_EN defined, three page-crossing branches -> fixupCount_OUT=3.
